ins_fetch: RTL and testbench

INS_FETCH -- requirements
Module: ins_fetch

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/ins_fetch_if.sv | 30 +++
 rtl/ins_fetch_pc.sv | 23 ++
 rtl/ins_fetch.sv | 109 ++++++++++
 tb/tb_ins_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-unit types, length-field encodings and reset PC
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_EXT   = 2'd2,
      ST_ISSUE = 2'd3
   } fetch_state_e;

   localparam int LEN_MSB = 13;
   localparam int LEN_LSB = 12;

   localparam logic [1:0] LEN_1W  = 2'b00;
   localparam logic [1:0] LEN_2W  = 2'b01;
   localparam logic [1:0] LEN_3W  = 2'b10;
   localparam logic [1:0] LEN_BAD = 2'b11;

   localparam logic [15:0] RESET_PC = 16'h0000;

   // Extension words that follow the first word; an illegal length fetches nothing more.
   function automatic logic [1:0] ext_words(input logic [1:0] len);
      logic [1:0] n;
      case (len)
         LEN_1W:  n = 2'd0;
         LEN_2W:  n = 2'd1;
         LEN_3W:  n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// rtl/ins_fetch_if.sv - ROM read port and decoder issue port of the fetch unit
interface ins_fetch_if;

   logic        rom_req;
   logic [15:0] rom_addr;
   logic        rom_ack;
   logic [15:0] rom_data;

   logic [15:0] Ins_addr;
   logic [15:0] Ins_ext0;
   logic [15:0] Ins_ext1;
   logic        Ins_load;
   logic        ins_illegal;
   logic        dec_ready;

   modport master (
      output rom_req, rom_addr,
      input  rom_ack, rom_data,
      output Ins_addr, Ins_ext0, Ins_ext1, Ins_load, ins_illegal,
      input  dec_ready
   );

   modport slave (
      input  rom_req, rom_addr,
      output rom_ack, rom_data,
      input  Ins_addr, Ins_ext0, Ins_ext1, Ins_load, ins_illegal,
      output dec_ready
   );

endinterface

// File: rtl/ins_fetch_pc.sv
// rtl/ins_fetch_pc.sv - program counter with redirect priority and silent 16-bit wrap
module ins_fetch_pc
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        inc,
   output logic [15:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + 16'd1;
      end
   end

endmodule

// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - multi-word instruction fetch FSM feeding the decoder
module ins_fetch
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        pc_load,
   input  logic [15:0] pc_load_val,
   output logic [15:0] pc,
   ins_fetch_if.master bus
);

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] REQ   = ST_REQ;
   localparam logic [1:0] EXT   = ST_EXT;
   localparam logic [1:0] ISSUE = ST_ISSUE;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [1:0]  words_left;
   logic        ext_sel;
   logic        fetching;
   logic        take;
   logic [1:0]  len_field;
   logic [15:0] ins_addr_q;
   logic [15:0] ins_ext0_q;
   logic [15:0] ins_ext1_q;
   logic        ins_illegal_q;

   assign fetching  = (state == REQ) || (state == EXT);
   // A redirect in the same cycle as an ack wins; the returned word is dropped.
   assign take      = fetching && bus.rom_ack && !pc_load;
   assign len_field = bus.rom_data[LEN_MSB:LEN_LSB];

   assign bus.rom_req     = fetching;
   assign bus.rom_addr    = fetching ? pc : 16'h0000;
   assign bus.Ins_load    = (state == ISSUE);
   assign bus.Ins_addr    = ins_addr_q;
   assign bus.Ins_ext0    = ins_ext0_q;
   assign bus.Ins_ext1    = ins_ext1_q;
   assign bus.ins_illegal = ins_illegal_q;

   ins_fetch_pc u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (pc_load),
      .load_val (pc_load_val),
      .inc      (take),
      .pc       (pc)
   );

   always_comb begin
      state_nxt = state;
      if (pc_load) begin
         state_nxt = fetch_en ? REQ : IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (fetch_en) state_nxt = REQ;
            end
            REQ: begin
               if (bus.rom_ack) begin
                  state_nxt = (ext_words(len_field) != 2'd0) ? EXT : ISSUE;
               end
            end
            EXT: begin
               if (bus.rom_ack && (words_left == 2'd1)) state_nxt = ISSUE;
            end
            ISSUE: begin
               if (bus.dec_ready) state_nxt = fetch_en ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         words_left    <= 2'd0;
         ext_sel       <= 1'b0;
         ins_addr_q    <= 16'h0000;
         ins_ext0_q    <= 16'h0000;
         ins_ext1_q    <= 16'h0000;
         ins_illegal_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (take && (state == REQ)) begin
            // New instruction: stale extension words from the previous one must not leak.
            ins_addr_q    <= bus.rom_data;
            ins_ext0_q    <= 16'h0000;
            ins_ext1_q    <= 16'h0000;
            ins_illegal_q <= (len_field == LEN_BAD);
            words_left    <= ext_words(len_field);
            ext_sel       <= 1'b0;
         end else if (take && (state == EXT)) begin
            if (!ext_sel) begin
               ins_ext0_q <= bus.rom_data;
            end else begin
               ins_ext1_q <= bus.rom_data;
            end
            ext_sel    <= 1'b1;
            words_left <= words_left - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_ins_fetch.sv
// tb/tb_ins_fetch.sv - scoreboard bench for ins_fetch with random ROM, stalls and redirects
module tb_ins_fetch;

   typedef struct packed {
      logic [15:0] w0;
      logic [15:0] e0;
      logic [15:0] e1;
      logic [15:0] npc;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic        pc_load = 1'b0;
   logic [15:0] pc_load_val = 16'h0000;
   logic [15:0] pc;

   ins_fetch_if bus();

   ins_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_en    (fetch_en),
      .pc_load     (pc_load),
      .pc_load_val (pc_load_val),
      .pc          (pc),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [0:65535];
   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          ack_mode = 1'b1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference: an instruction at address a is its first word plus 0/1/2 following words.
   function automatic exp_t model_at(input logic [15:0] a);
      exp_t        e;
      logic [15:0] w;
      int          lf;
      int          n_ext;
      w     = rom[a];
      lf    = int'(w[13:12]);
      n_ext = (lf == 1) ? 1 : ((lf == 2) ? 2 : 0);
      e.w0  = w;
      e.e0  = (n_ext >= 1) ? rom[a + 16'd1] : 16'h0000;
      e.e1  = (n_ext == 2) ? rom[a + 16'd2] : 16'h0000;
      e.ill = (lf == 3);
      e.npc = a + 16'(n_ext + 1);
      return e;
   endfunction

   task automatic push_seg(input logic [15:0] start, input int n);
      logic [15:0] a;
      exp_t        e;
      a = start;
      for (int i = 0; i < n; i++) begin
         e = model_at(a);
         exp_q.push_back(e);
         a = e.npc;
      end
   endtask

   task automatic wait_addr(input logic [15:0] a, input string name);
      int n;
      n = 0;
      while (!(bus.rom_req && bus.rom_addr == a) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL %s: rom_addr %h never requested, last %h", name, a, bus.rom_addr);
      end
   endtask

   task automatic wait_load(input string name);
      int n;
      n = 0;
      while (!bus.Ins_load && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL %s: Ins_load got 0 expected 1 within 50 cycles", name);
      end
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d instructions never issued, expected 0", name, exp_q.size());
      end
   endtask

   task automatic run_segment(input logic [15:0] start, input int n_in);
      int          acc;
      int          cyc;
      int          redirs;
      int          n;
      logic        accept;
      logic [15:0] ns;
      acc = 0; cyc = 0; redirs = 0; n = n_in;
      push_seg(start, n);
      pc_load = 1'b1; pc_load_val = start; fetch_en = 1'b1; bus.dec_ready = 1'b0;
      @(negedge clk);
      pc_load = 1'b0;
      while (acc < n && cyc < 3000) begin
         bus.dec_ready = ($urandom_range(0, 3) != 0);
         accept = bus.Ins_load && bus.dec_ready;
         if (redirs < 3 && $urandom_range(0, 99) < 3) begin
            redirs++;
            while (exp_q.size() > (accept ? 1 : 0)) void'(exp_q.pop_back());
            ns  = 16'($urandom);
            n   = $urandom_range(1, 4);
            acc = 0;
            push_seg(ns, n);
            pc_load = 1'b1; pc_load_val = ns; fetch_en = 1'b1;
         end else begin
            pc_load = 1'b0;
            if (accept) acc++;
            fetch_en = (acc < n) ? ($urandom_range(0, 9) != 0) : 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      pc_load = 1'b0; fetch_en = 1'b0;
      checks++;
      if (cyc >= 3000) begin
         errors++;
         $display("FAIL seg_timeout: accepted %0d expected %0d", acc, n);
      end
      wait_empty("segment");
      @(negedge clk);
      chk("seg_idle_load", 16'(bus.Ins_load), 16'd0);
      chk("seg_idle_req", 16'(bus.rom_req), 16'd0);
   endtask

   // ROM model: same-cycle data when acking; spurious acks while idle must be ignored.
   initial begin
      bus.rom_ack = 1'b0;
      bus.rom_data = 16'h0000;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.rom_ack = 1'b0;
         end else if (bus.rom_req) begin
            if (ack_mode || $urandom_range(0, 2) != 0) begin
               bus.rom_ack = 1'b1;
               bus.rom_data = rom[bus.rom_addr];
            end else begin
               bus.rom_ack = 1'b0;
               bus.rom_data = 16'($urandom);
            end
         end else begin
            bus.rom_ack = ($urandom_range(0, 5) == 0);
            bus.rom_data = 16'($urandom);
         end
      end
   end

   // Monitor: pops on every accepted issue and checks stalled outputs stay frozen.
   initial begin
      exp_t        e;
      logic        hold;
      logic [15:0] h_addr, h_e0, h_e1, h_pc;
      logic        h_ill;
      hold = 1'b0;
      h_addr = '0; h_e0 = '0; h_e1 = '0; h_pc = '0; h_ill = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("hold_load", 16'(bus.Ins_load), 16'd1);
               chk("hold_addr", bus.Ins_addr, h_addr);
               chk("hold_ext0", bus.Ins_ext0, h_e0);
               chk("hold_ext1", bus.Ins_ext1, h_e1);
               chk("hold_ill", 16'(bus.ins_illegal), 16'(h_ill));
               chk("hold_pc", pc, h_pc);
               chk("hold_req", 16'(bus.rom_req), 16'd0);
            end
            if (bus.Ins_load && bus.dec_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_issue: got Ins_addr=%h expected no issue", bus.Ins_addr);
               end else begin
                  e = exp_q.pop_front();
                  chk("issue_addr", bus.Ins_addr, e.w0);
                  chk("issue_ext0", bus.Ins_ext0, e.e0);
                  chk("issue_ext1", bus.Ins_ext1, e.e1);
                  chk("issue_ill", 16'(bus.ins_illegal), 16'(e.ill));
                  chk("issue_pc", pc, e.npc);
               end
            end
            hold   = bus.Ins_load && !bus.dec_ready && !pc_load;
            h_addr = bus.Ins_addr;
            h_e0   = bus.Ins_ext0;
            h_e1   = bus.Ins_ext1;
            h_ill  = bus.ins_illegal;
            h_pc   = pc;
         end
      end
   end

   initial begin
      bus.dec_ready = 1'b0;
      for (int i = 0; i < 65536; i++) rom[i] = 16'($urandom);
      rom[16'h0000] = 16'h0123;
      rom[16'h0004] = 16'h2A00;
      rom[16'h0005] = 16'hBEEF;
      rom[16'h0006] = 16'hCAFE;
      rom[16'h0100] = 16'h0456;
      rom[16'hFFFF] = 16'h3000;

      repeat (3) @(negedge clk);
      chk("rst_rom_req", 16'(bus.rom_req), 16'd0);
      chk("rst_rom_addr", bus.rom_addr, 16'h0000);
      chk("rst_ins_addr", bus.Ins_addr, 16'h0000);
      chk("rst_ext0", bus.Ins_ext0, 16'h0000);
      chk("rst_ext1", bus.Ins_ext1, 16'h0000);
      chk("rst_load", 16'(bus.Ins_load), 16'd0);
      chk("rst_ill", 16'(bus.ins_illegal), 16'd0);
      chk("rst_pc", pc, 16'h0000);
      rst_n = 1'b1;

      // Single word from address 0, acked in the request cycle.
      ack_mode = 1'b1; bus.dec_ready = 1'b1; fetch_en = 1'b1;
      push_seg(16'h0000, 1);
      @(negedge clk);
      chk("first_req", 16'(bus.rom_req), 16'd1);
      chk("first_addr", bus.rom_addr, 16'h0000);
      fetch_en = 1'b0;
      @(negedge clk);
      chk("single_load", 16'(bus.Ins_load), 16'd1);
      @(negedge clk);
      chk("single_load_fall", 16'(bus.Ins_load), 16'd0);
      chk("single_pc", pc, 16'h0001);
      wait_empty("single");

      // Three-word instruction, then a five-cycle decoder stall.
      bus.dec_ready = 1'b0; pc_load = 1'b1; pc_load_val = 16'h0004; fetch_en = 1'b1;
      push_seg(16'h0004, 1);
      @(negedge clk);
      pc_load = 1'b0; fetch_en = 1'b0;
      wait_load("three_word");
      for (int i = 0; i < 5; i++) begin
         chk("stall_load", 16'(bus.Ins_load), 16'd1);
         chk("stall_ext1", bus.Ins_ext1, 16'hCAFE);
         chk("stall_pc", pc, 16'h0007);
         @(negedge clk);
      end
      bus.dec_ready = 1'b1;
      chk("stall_release_load", 16'(bus.Ins_load), 16'd1);
      @(negedge clk);
      chk("stall_done_load", 16'(bus.Ins_load), 16'd0);
      wait_empty("stall");

      // Redirect during EXT while the ROM acks: the partial instruction is dropped.
      pc_load = 1'b1; pc_load_val = 16'h0004; fetch_en = 1'b1;
      push_seg(16'h0004, 1);
      @(negedge clk);
      pc_load = 1'b0;
      wait_addr(16'h0005, "redir_ext");
      exp_q.delete();
      push_seg(16'h0100, 1);
      pc_load = 1'b1; pc_load_val = 16'h0100;
      @(negedge clk);
      pc_load = 1'b0; fetch_en = 1'b0;
      chk("redir_req", 16'(bus.rom_req), 16'd1);
      chk("redir_addr", bus.rom_addr, 16'h0100);
      chk("redir_noload", 16'(bus.Ins_load), 16'd0);
      wait_empty("redir");

      // PC wrap with an illegal length field.
      pc_load = 1'b1; pc_load_val = 16'hFFFF; fetch_en = 1'b1;
      push_seg(16'hFFFF, 1);
      @(negedge clk);
      pc_load = 1'b0; fetch_en = 1'b0;
      wait_load("wrap");
      chk("wrap_ill", 16'(bus.ins_illegal), 16'd1);
      chk("wrap_pc", pc, 16'h0000);
      wait_empty("wrap");

      // Asynchronous reset in the middle of EXT.
      pc_load = 1'b1; pc_load_val = 16'h0004; fetch_en = 1'b1;
      @(negedge clk);
      pc_load = 1'b0;
      wait_addr(16'h0005, "rst_ext");
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_req", 16'(bus.rom_req), 16'd0);
      chk("arst_addr", bus.rom_addr, 16'h0000);
      chk("arst_ins_addr", bus.Ins_addr, 16'h0000);
      chk("arst_ext0", bus.Ins_ext0, 16'h0000);
      chk("arst_ext1", bus.Ins_ext1, 16'h0000);
      chk("arst_load", 16'(bus.Ins_load), 16'd0);
      chk("arst_ill", 16'(bus.ins_illegal), 16'd0);
      chk("arst_pc", pc, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      push_seg(16'h0000, 1);
      @(negedge clk);
      chk("rst_first_req", 16'(bus.rom_req), 16'd1);
      chk("rst_first_addr", bus.rom_addr, 16'h0000);
      fetch_en = 1'b0;
      wait_empty("post_reset");

      // Randomised runs: random ROM latency, stalls, fetch_en gaps and redirects.
      ack_mode = 1'b0;
      for (int s = 0; s < 30; s++) begin
         run_segment(16'($urandom), $urandom_range(1, 12));
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
